// File: rtl/jtbubl_gfx_rom.sv
// Graphics ROM front-end: a one-entry, 32-bit-line cache over the SDRAM read port.
// Each SDRAM read fetches an even/odd pair of 16-bit ROM words.
module jtbubl_gfx_rom #(
  parameter logic [21:0] BASE     = 22'h0,
  parameter int unsigned DW_SDRAM = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gfx_cs,
  input  logic [17:0]         gfx_addr,
  output logic [15:0]         gfx_data,
  output logic                gfx_ok,
  output logic                sdram_req,
  output logic [21:0]         sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [DW_SDRAM-1:0] sdram_data
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [16:0] tag_q, tag_d;
  logic        valid_q, valid_d;
  logic [16:0] pend_q, pend_d;
  logic        ok_q, ok_d;
  logic [15:0] dout_q, dout_d;
  logic [17:0] ok_addr_q, ok_addr_d;
  logic        hit;

  assign hit = valid_q && (tag_q == gfx_addr[17:1]);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    pend_d    = pend_q;
    ok_d      = 1'b0;
    dout_d    = dout_q;
    ok_addr_d = ok_addr_q;
    case (state_q)
      StIdle: begin
        if (gfx_cs) begin
          if (hit) begin
            ok_d      = 1'b1;
            dout_d    = gfx_addr[0] ? data_q[31:16] : data_q[15:0];
            ok_addr_d = gfx_addr;
          end else begin
            pend_d  = gfx_addr[17:1];
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (sdram_ack) begin
          // Controllers with zero read latency deliver data together with the ack
          if (sdram_rdy) begin
            data_d  = sdram_data[31:0];
            tag_d   = pend_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (sdram_rdy) begin
          data_d  = sdram_data[31:0];
          tag_d   = pend_q;
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      data_q    <= 32'h0;
      tag_q     <= 17'h0;
      valid_q   <= 1'b0;
      pend_q    <= 17'h0;
      ok_q      <= 1'b0;
      dout_q    <= 16'h0;
      ok_addr_q <= 18'h0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      ok_q      <= ok_d;
      dout_q    <= dout_d;
      ok_addr_q <= ok_addr_d;
    end
  end

  // The registered ok is only trusted while the address it was computed for is still presented
  assign gfx_ok     = ok_q && (gfx_addr == ok_addr_q);
  assign gfx_data   = dout_q;
  assign sdram_req  = (state_q == StReq);
  assign sdram_addr = BASE + {5'b0, pend_q};

endmodule

// File: tb/tb_jtbubl_gfx_rom.sv
// Self-checking bench for jtbubl_gfx_rom: directed scenarios plus randomized accesses
// checked against a one-entry cache model driven by a scripted SDRAM controller.
module tb_jtbubl_gfx_rom;

  localparam logic [21:0] BASE = 22'h100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gfx_cs;
  logic [17:0] gfx_addr;
  logic [15:0] gfx_data;
  logic        gfx_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        sdram_rdy;
  logic [31:0] sdram_data;

  int checks = 0;
  int errors = 0;

  // Reference model of the cache contents
  bit          m_valid;
  int unsigned m_tag;
  int unsigned m_data;
  logic [17:0] cur_addr;

  jtbubl_gfx_rom #(.BASE(BASE), .DW_SDRAM(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gfx_cs     (gfx_cs),
    .gfx_addr   (gfx_addr),
    .gfx_data   (gfx_data),
    .gfx_ok     (gfx_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_rdy  (sdram_rdy),
    .sdram_data (sdram_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] exp_addr(input logic [17:0] a);
    int unsigned s;
    s = (int'(BASE) + int'(a) / 2) % 32'h400000;
    return s[21:0];
  endfunction

  function automatic logic [15:0] exp_half(input logic [17:0] a);
    int unsigned h;
    h = (int'(a) % 2 == 1) ? m_data / 65536 : m_data % 65536;
    return h[15:0];
  endfunction

  function automatic bit model_hit(input logic [17:0] a);
    return m_valid && (m_tag == int'(a) / 2);
  endfunction

  // Scripted controller: ack after ack_dly REQ cycles, rdy after rdy_dly WAIT cycles
  // (or together with ack); new_addr is presented once the transfer is in WAIT.
  task automatic serve(input int ack_dly, input int rdy_dly, input logic [31:0] d,
                       input bit same, input logic [17:0] tag_addr, input logic [17:0] new_addr);
    for (int i = 0; i < ack_dly; i++) begin
      checks++;
      if (sdram_req !== 1'b1 || gfx_ok !== 1'b0) begin
        errors++;
        $display("FAIL req_hold: req=%b ok=%b, required req=1 ok=0", sdram_req, gfx_ok);
      end
      tick();
    end
    sdram_ack = 1'b1;
    if (same) begin
      sdram_rdy  = 1'b1;
      sdram_data = d;
    end
    tick();
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    if (!same) begin
      gfx_addr = new_addr;
      cur_addr = new_addr;
      for (int i = 0; i < rdy_dly; i++) begin
        checks++;
        if (sdram_req !== 1'b0 || gfx_ok !== 1'b0) begin
          errors++;
          $display("FAIL wait_state: req=%b ok=%b, required req=0 ok=0", sdram_req, gfx_ok);
        end
        tick();
      end
      sdram_rdy  = 1'b1;
      sdram_data = d;
      tick();
      sdram_rdy = 1'b0;
    end
    m_valid = 1'b1;
    m_tag   = int'(tag_addr) / 2;
    m_data  = d;
    checks++;
    if (sdram_req !== 1'b0 || gfx_ok !== 1'b0) begin
      errors++;
      $display("FAIL fill_cycle: req=%b ok=%b, required req=0 ok=0", sdram_req, gfx_ok);
    end
  endtask

  // One access with gfx_cs held; misses are served and then read back as a hit
  task automatic access(input logic [17:0] a, input int ack_dly, input int rdy_dly,
                        input bit same, input logic [31:0] d);
    bit changed;
    bit hit;
    changed  = (a != cur_addr);
    gfx_cs   = 1'b1;
    gfx_addr = a;
    cur_addr = a;
    #1;
    if (changed) begin
      checks++;
      if (gfx_ok !== 1'b0) begin
        errors++;
        $display("FAIL addr_qualify: ok=%b after change to %h, required 0", gfx_ok, a);
      end
    end
    hit = model_hit(a);
    tick();
    if (hit) begin
      checks++;
      if (sdram_req !== 1'b0 || gfx_ok !== 1'b1 || gfx_data !== exp_half(a)) begin
        errors++;
        $display("FAIL hit %h: req=%b ok=%b data=%h, required req=0 ok=1 data=%h",
                 a, sdram_req, gfx_ok, gfx_data, exp_half(a));
      end
    end else begin
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== exp_addr(a) || gfx_ok !== 1'b0) begin
        errors++;
        $display("FAIL miss %h: req=%b addr=%h ok=%b, required req=1 addr=%h ok=0",
                 a, sdram_req, sdram_addr, gfx_ok, exp_addr(a));
      end
      serve(ack_dly, rdy_dly, d, same, a, a);
      tick();
      checks++;
      if (gfx_ok !== 1'b1 || gfx_data !== exp_half(a)) begin
        errors++;
        $display("FAIL after_fill %h: ok=%b data=%h, required ok=1 data=%h",
                 a, gfx_ok, gfx_data, exp_half(a));
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    gfx_cs     = 1'b0;
    gfx_addr   = 18'h0;
    sdram_ack  = 1'b0;
    sdram_rdy  = 1'b0;
    sdram_data = 32'h0;
    cur_addr   = 18'h0;
    m_valid    = 1'b0;
    m_tag      = 0;
    m_data     = 0;
    tick();
    tick();
    checks++;
    if (gfx_ok !== 1'b0 || sdram_req !== 1'b0 || gfx_data !== 16'h0) begin
      errors++;
      $display("FAIL reset: ok=%b req=%b data=%h, required 0 0 0000", gfx_ok, sdram_req, gfx_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    access(18'h00010, 1, 2, 1'b0, 32'hBEEF_1234);
    checks++;
    if (gfx_data !== 16'h1234) begin
      errors++;
      $display("FAIL cold_miss_data: data=%h, required 1234", gfx_data);
    end
  endtask

  task automatic test_pair_hit();
    access(18'h00011, 0, 0, 1'b0, 32'h0);
    checks++;
    if (gfx_data !== 16'hBEEF || gfx_ok !== 1'b1) begin
      errors++;
      $display("FAIL pair_hit: ok=%b data=%h, required ok=1 data=beef", gfx_ok, gfx_data);
    end
  endtask

  task automatic test_addr_change();
    logic [31:0] d1;
    logic [31:0] d2;
    d1       = $urandom;
    d2       = $urandom;
    gfx_cs   = 1'b1;
    gfx_addr = 18'h00020;
    cur_addr = 18'h00020;
    tick();
    serve(0, 2, d1, 1'b0, 18'h00020, 18'h00100);
    tick();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h100080 || gfx_ok !== 1'b0) begin
      errors++;
      $display("FAIL addr_change_refetch: req=%b addr=%h ok=%b, required req=1 addr=100080 ok=0",
               sdram_req, sdram_addr, gfx_ok);
    end
    serve(1, 1, d2, 1'b0, 18'h00100, 18'h00100);
    tick();
    checks++;
    if (gfx_ok !== 1'b1 || gfx_data !== d2[15:0]) begin
      errors++;
      $display("FAIL addr_change_data: ok=%b data=%h, required ok=1 data=%h",
               gfx_ok, gfx_data, d2[15:0]);
    end
    // The earlier line was evicted by the one-entry cache
    access(18'h00021, 2, 0, 1'b0, $urandom);
  endtask

  task automatic test_same_cycle();
    access(18'h00200, 0, 0, 1'b1, 32'hCAFE_F00D);
    access(18'h00201, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_wait();
    gfx_cs   = 1'b1;
    gfx_addr = 18'h00040;
    cur_addr = 18'h00040;
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n      = 1'b1;
    m_valid    = 1'b0;
    gfx_cs     = 1'b0;
    sdram_rdy  = 1'b1;
    sdram_data = 32'h5555_AAAA;
    tick();
    sdram_rdy = 1'b0;
    tick();
    checks++;
    if (gfx_ok !== 1'b0 || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL stale_rdy: ok=%b req=%b, required 0 0", gfx_ok, sdram_req);
    end
    access(18'h00040, 1, 1, 1'b0, 32'h1357_2468);
  endtask

  task automatic test_cs_drop();
    logic [15:0] held;
    access(18'h00201, 0, 0, 1'b0, $urandom);
    held   = exp_half(18'h00201);
    gfx_cs = 1'b0;
    tick();
    checks++;
    if (gfx_ok !== 1'b0 || gfx_data !== held) begin
      errors++;
      $display("FAIL cs_drop: ok=%b data=%h, required ok=0 data=%h", gfx_ok, gfx_data, held);
    end
    // A transfer started before cs drops still fills the cache
    gfx_cs   = 1'b1;
    gfx_addr = 18'h00300;
    cur_addr = 18'h00300;
    tick();
    gfx_cs = 1'b0;
    serve(1, 1, 32'h0BAD_F00D, 1'b0, 18'h00300, 18'h00300);
    tick();
    access(18'h00301, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_stray();
    gfx_cs     = 1'b0;
    sdram_ack  = 1'b1;
    sdram_rdy  = 1'b1;
    sdram_data = 32'hDEAD_DEAD;
    tick();
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    tick();
    access(18'h00300, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [17:0] a;
    for (int i = 0; i < 60; i++) begin
      a = 18'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = a | 18'h3FFF0;
      if ($urandom_range(0, 4) == 0) begin
        gfx_cs = 1'b0;
        tick();
      end
      access(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_pair_hit();
    test_addr_change();
    test_same_cycle();
    test_reset_mid_wait();
    test_cs_drop();
    test_stray();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtbubl_gfx_rom.md
JTBUBL_GFX_ROM -- requirements
Module: jtbubl_gfx_rom

Interface
REQ-001 The module SHALL have parameter BASE, default 22'h0, the SDRAM word offset of the graphics ROM region.
REQ-002 The module SHALL have parameter DW_SDRAM, default 32, the SDRAM read width; only 32 is supported.
REQ-003 The module SHALL have port clk, input, 1, the system clock (48 MHz); it is the only clock.
REQ-004 The module SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-005 The module SHALL have port gfx_cs, input, 1, the graphics fetch request, level-held by the video engine.
REQ-006 The module SHALL have port gfx_addr, input, 18, the 16-bit-word address into the graphics ROM.
REQ-007 The module SHALL have port gfx_data, output, 16, the ROM word for the current gfx_addr.
REQ-008 The module SHALL have port gfx_ok, output, 1, high when gfx_data is valid for the current gfx_addr with gfx_cs high.
REQ-009 The module SHALL have port sdram_req, output, 1, the SDRAM read request, level-held until acknowledged.
REQ-010 The module SHALL have port sdram_addr, output, 22, the SDRAM word address, equal to BASE + {4'b0, gfx_addr[17:1]}, computed modulo 2^22.
REQ-011 The module SHALL have port sdram_ack, input, 1, a one-cycle pulse when the controller accepts the request.
REQ-012 The module SHALL have port sdram_rdy, input, 1, a one-cycle pulse when sdram_data is valid.
REQ-013 The module SHALL have port sdram_data, input, 32, the read data: the low half is the even word and the high half is the odd word.

Function
REQ-014 The module SHALL hold a one-entry cache: a 32-bit data word, a 17-bit tag and a valid bit.
REQ-015 The FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-016 In IDLE, gfx_cs high with the tag matching gfx_addr[17:1] and valid set is a hit: gfx_ok SHALL be registered high on the next cycle.
REQ-017 On a hit, gfx_data SHALL be the cache low half if gfx_addr[0]=0 and the high half if gfx_addr[0]=1, registered with gfx_ok.
REQ-018 In IDLE, gfx_cs high with a miss SHALL latch gfx_addr[17:1] as the pending tag, set sdram_req, drive sdram_addr, and go to REQ.
REQ-019 In REQ, sdram_req and sdram_addr SHALL be held stable; sdram_ack SHALL clear sdram_req and move the FSM to WAIT.
REQ-020 In WAIT, sdram_rdy SHALL load the cache data, set the tag to the pending tag, set valid, and return to IDLE.
REQ-021 sdram_rdy arriving in the same cycle as sdram_ack SHALL be honoured: REQ goes directly to IDLE with the cache filled.
REQ-022 gfx_ok SHALL be low in REQ, in WAIT, and on the cycle of the fill; the earliest gfx_ok after a miss is the cycle after the return to IDLE.
REQ-023 Miss latency is 3 cycles plus the controller latency, measured from gfx_cs rising to gfx_ok.
REQ-024 A gfx_addr change while in REQ or WAIT SHALL NOT abort the transfer; the fill completes, then IDLE re-evaluates the new address.
REQ-025 Any gfx_addr change in IDLE SHALL force gfx_ok low in the same cycle (combinational qualify) until the hit/miss is re-evaluated.
REQ-026 gfx_cs low SHALL force gfx_ok low from the next cycle; a transfer already in progress still completes and fills the cache.
REQ-027 Two addresses differing only in bit 0 SHALL share one SDRAM read; the second is a hit.
REQ-028 sdram_ack or sdram_rdy arriving in IDLE SHALL be ignored and leave the cache unchanged.
REQ-029 gfx_data SHALL hold its last value whenever gfx_ok is low.

Reset
REQ-030 rst_n low at a clock edge SHALL set: FSM to IDLE; sdram_req=0; gfx_ok=0; gfx_data=16'h0; valid=0; tag=0; cache data=0.
REQ-031 Reset asserted during REQ or WAIT SHALL abandon the transfer; a later sdram_rdy SHALL be ignored, per REQ-028.
REQ-032 On the first cycle after rst_n rises, any gfx_cs SHALL be treated as a miss.

Verification
REQ-033 Cold miss: after reset, gfx_cs=1, gfx_addr=18'h00010, BASE=22'h100000 -> sdram_req=1 and sdram_addr=22'h100008; ack at +2 and rdy=32'hBEEF_1234 at +5 -> gfx_data=16'h1234 with gfx_ok=1.
REQ-034 Pair hit: following REQ-033, gfx_addr=18'h00011 -> no sdram_req, gfx_ok=1 next cycle, gfx_data=16'hBEEF.
REQ-035 Address change mid-fetch: in WAIT, gfx_addr changes to 18'h00100 -> the first fill completes, then a new sdram_req with sdram_addr=22'h100080 and gfx_ok low throughout.
REQ-036 Same-cycle ack and rdy: the FSM goes REQ->IDLE in one cycle and the cache is valid.
REQ-037 Reset mid-WAIT: rst_n=0 for 1 cycle, then a stale sdram_rdy -> valid stays 0, gfx_ok=0, and the next gfx_cs issues a fresh sdram_req.
REQ-038 gfx_cs drop on a hit: gfx_cs=0 -> gfx_ok=0 on the next cycle and gfx_data is unchanged.
